wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: writeback data width.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 5: register index width (32 GPRs).
REQ-003 The block SHALL have port clk  input  1: rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 The block SHALL have ports exu_wb_valid_i  input  1, exu_wb_rd_i  input  REG_ADDR_WIDTH, exu_wb_dat_i  input  DATA_WIDTH: execute-unit writeback request.
REQ-006 The block SHALL have port exu_wb_ready_o  output  1: execute-unit request accepted this cycle.
REQ-007 The block SHALL have ports lsu_wb_valid_i, lsu_wb_rd_i, lsu_wb_dat_i (input) and lsu_wb_ready_o (output), with the same widths and meanings for the load/store unit.
REQ-008 The block SHALL have ports rf_wen_o  output  1, rf_rd_o  output  REG_ADDR_WIDTH, rf_dat_o  output  DATA_WIDTH: single register-file write port.
REQ-009 The block SHALL have ports issue_i  input  1, issue_use_rd_i  input  1, issue_rd_i  input  REG_ADDR_WIDTH: decode is issuing an instruction that will write issue_rd_i.
REQ-010 The block SHALL have ports chk_use_rs1_i, chk_use_rs2_i (input 1) and chk_rs1_i, chk_rs2_i (input REG_ADDR_WIDTH): decode source operands to hazard-check.
REQ-011 The block SHALL have port stall_o  output  1: decode must not issue this cycle.

Function
REQ-012 A request SHALL complete on a cycle with valid and ready both high; valid, rd and dat SHALL be held stable by the requester until completion.
REQ-013 At most one request SHALL be granted per cycle; ready SHALL be combinational from both valid inputs and the round-robin pointer.
REQ-014 With only one requester valid, that requester SHALL be granted.
REQ-015 With both valid, the requester not granted most recently in a two-way conflict SHALL be granted; the pointer SHALL update only on conflict cycles.
REQ-016 A grant in cycle N SHALL produce rf_wen_o=1 with the granted rd/dat in cycle N+1 (registered, 1-cycle latency).
REQ-017 rf_wen_o SHALL be 0 in any cycle following a cycle with no grant, and when the granted rd is 0 (handshake still completes).
REQ-018 The scoreboard SHALL hold 32 busy bits, with bit 0 always 0.
REQ-019 issue_i && issue_use_rd_i && !stall_o && issue_rd_i!=0 SHALL set busy[issue_rd_i] at the clock edge.
REQ-020 A cycle with rf_wen_o=1 SHALL clear busy[rf_rd_o] at the clock edge.
REQ-021 A simultaneous set and clear of the same index SHALL leave the bit set.
REQ-022 stall_o SHALL be (chk_use_rs1_i && busy[chk_rs1_i]) || (chk_use_rs2_i && busy[chk_rs2_i]) || (issue_use_rd_i && busy[issue_rd_i]), which blocks RAW and WAW hazards; there SHALL be no bypass.
REQ-023 A write to a non-busy index SHALL be performed normally without a scoreboard error.

Reset
REQ-024 While rst_n=0 at a clock edge: rf_wen_o=0, rf_rd_o=0, rf_dat_o=0, all busy bits=0, and the pointer SHALL favour EXU.
REQ-025 During reset, both ready outputs SHALL be 0 and stall_o SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL drop any granted-but-unwritten request; no RF write SHALL occur in the cycle after reset.

Structure
REQ-027 The package params.vh SHALL hold the requester IDs (ARB_EXU=0, ARB_LSU=1) and shall reuse the existing DATA_WIDTH/REG_ADDR_WIDTH constants.
REQ-028 The scoreboard SHALL be a sub-module named wb_scoreboard (busy bits, set/clear, stall compare); the arbitration and output register SHALL stay in wb_arbiter.
REQ-029 The implementation SHALL be 120-400 lines of RTL and fully synthesizable, with no DPI.

Verification
REQ-030 EXU alone valid, rd=5, dat=0x1234 -> exu_wb_ready_o=1 in cycle N; rf_wen_o=1, rf_rd_o=5, rf_dat_o=0x1234 in cycle N+1.
REQ-031 Both valid for 4 cycles, holding on grant (new data each time) -> grants EXU, LSU, EXU, LSU; rf_wen_o high 4 consecutive cycles.
REQ-032 Issue with rd=7, then check with rs1=7 -> stall_o=1 until the cycle after rf_wen_o with rd=7; stall_o=0 in cycle N+2 of that grant.
REQ-033 Issue with rd=0, then a writeback to rd=0 -> busy unchanged, ready=1, rf_wen_o=0.
REQ-034 Issue of rd=3 in the same cycle that rf_wen_o writes rd=3 -> busy[3] remains 1 and a later check on rs2=3 stalls.
REQ-035 Grant in cycle N with rst_n=0 in cycle N -> rf_wen_o=0 in N+1, all busy clear, and the next conflict is granted to EXU.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter and its scoreboard.
// Requester IDs double as the round-robin pointer encoding.
package wb_arbiter_pkg;

    // Datapath widths used by the rest of the core.
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Writeback requester identifiers.
    typedef enum logic {
        ARB_EXU = 1'b0,
        ARB_LSU = 1'b1
    } arb_id_t;

    // Returns the requester that is not the one given.
    function automatic arb_id_t arb_other(input arb_id_t id);
        return (id == ARB_EXU) ? ARB_LSU : ARB_EXU;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Register busy-bit scoreboard.
// A destination register is marked busy when decode issues a writer, and it
// is released when the arbiter writes that register to the register file.
// Decode stalls on any source or destination that is still busy, which
// covers both RAW and WAW hazards. There is no bypass.
module wb_scoreboard
    import wb_arbiter_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = wb_arbiter_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Issue side: marks a destination busy.
    input  logic                      issue,
    input  logic                      issue_use_rd,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    // Source operands under hazard check.
    input  logic                      chk_use_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
    input  logic                      chk_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
    // Register-file write that releases a busy bit.
    input  logic                      clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] clr_idx,
    // Decode must hold off this cycle.
    output logic                      stall
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0]       busy;
    logic [NUM_REGS-1:0]       busy_next;
    logic [NUM_REGS-1:0]       set_mask;
    logic [NUM_REGS-1:0]       clr_mask;
    logic                      set_en;
    logic                      hazard_rs1;
    logic                      hazard_rs2;
    logic                      hazard_rd;

    // Hazard detection against the current busy bits; held low while in reset.
    always_comb begin
        hazard_rs1 = chk_use_rs1 && busy[chk_rs1];
        hazard_rs2 = chk_use_rs2 && busy[chk_rs2];
        hazard_rd  = issue_use_rd && busy[issue_rd];
        stall      = rst_n && (hazard_rs1 || hazard_rs2 || hazard_rd);
    end

    // A successful issue of a non-zero destination marks it busy.
    always_comb begin
        set_en = issue && issue_use_rd && !stall && (issue_rd != '0);
    end

    // Build set/clear masks; set is applied after clear so it wins on a tie.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_idx] = 1'b1;
        end
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Busy-bit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-way writeback arbiter between the execute unit and the load/store unit
// feeding a single register-file write port.
// Grants are combinational from the two valids and a round-robin pointer that
// only moves on conflict cycles; the register-file write is registered one
// cycle after the grant. Writes to register 0 still handshake but never
// assert the write enable. The busy-bit scoreboard lives in wb_scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = wb_arbiter_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = wb_arbiter_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Execute-unit writeback request.
    input  logic                      exu_wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] exu_wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     exu_wb_dat_i,
    output logic                      exu_wb_ready_o,
    // Load/store-unit writeback request.
    input  logic                      lsu_wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     lsu_wb_dat_i,
    output logic                      lsu_wb_ready_o,
    // Register-file write port.
    output logic                      rf_wen_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd_o,
    output logic [DATA_WIDTH-1:0]     rf_dat_o,
    // Decode issue and hazard check.
    input  logic                      issue_i,
    input  logic                      issue_use_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
    input  logic                      chk_use_rs1_i,
    input  logic                      chk_use_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2_i,
    output logic                      stall_o
);

    arb_id_t                   ptr;
    arb_id_t                   ptr_next;
    logic                      conflict;
    logic                      exu_grant;
    logic                      lsu_grant;
    logic                      any_grant;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0]     sel_dat;

    // Grant decision: a lone requester wins, a conflict goes to the pointer.
    always_comb begin
        exu_grant = 1'b0;
        lsu_grant = 1'b0;
        conflict  = rst_n && exu_wb_valid_i && lsu_wb_valid_i;
        if (rst_n) begin
            if (conflict) begin
                exu_grant = (ptr == ARB_EXU);
                lsu_grant = (ptr == ARB_LSU);
            end else begin
                exu_grant = exu_wb_valid_i;
                lsu_grant = lsu_wb_valid_i;
            end
        end
        any_grant = exu_grant || lsu_grant;
    end

    // Ready mirrors the grant so each requester sees its handshake directly.
    always_comb begin
        exu_wb_ready_o = exu_grant;
        lsu_wb_ready_o = lsu_grant;
    end

    // Pointer moves to the loser of a conflict so it wins the next one.
    always_comb begin
        ptr_next = ptr;
        if (conflict) begin
            ptr_next = exu_grant ? arb_other(ARB_EXU) : arb_other(ARB_LSU);
        end
    end

    // Round-robin pointer register; favours the execute unit out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= ARB_EXU;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Mux the winning request onto the write path.
    always_comb begin
        sel_rd  = '0;
        sel_dat = '0;
        if (exu_grant) begin
            sel_rd  = exu_wb_rd_i;
            sel_dat = exu_wb_dat_i;
        end else if (lsu_grant) begin
            sel_rd  = lsu_wb_rd_i;
            sel_dat = lsu_wb_dat_i;
        end
    end

    // Register-file write register; register 0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen_o <= 1'b0;
            rf_rd_o  <= '0;
            rf_dat_o <= '0;
        end else if (any_grant) begin
            rf_wen_o <= (sel_rd != '0);
            rf_rd_o  <= sel_rd;
            rf_dat_o <= sel_dat;
        end else begin
            rf_wen_o <= 1'b0;
        end
    end

    wb_scoreboard #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue_i),
        .issue_use_rd(issue_use_rd_i),
        .issue_rd    (issue_rd_i),
        .chk_use_rs1 (chk_use_rs1_i),
        .chk_rs1     (chk_rs1_i),
        .chk_use_rs2 (chk_use_rs2_i),
        .chk_rs2     (chk_rs2_i),
        .clr_en      (rf_wen_o),
        .clr_idx     (rf_rd_o),
        .stall       (stall_o)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Inputs change 1ns after a rising edge; combinational outputs are checked
// 1ns later, registered outputs are checked in the cycle after the edge.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          exu_wb_valid_i;
    logic [AW-1:0] exu_wb_rd_i;
    logic [DW-1:0] exu_wb_dat_i;
    logic          exu_wb_ready_o;
    logic          lsu_wb_valid_i;
    logic [AW-1:0] lsu_wb_rd_i;
    logic [DW-1:0] lsu_wb_dat_i;
    logic          lsu_wb_ready_o;
    logic          rf_wen_o;
    logic [AW-1:0] rf_rd_o;
    logic [DW-1:0] rf_dat_o;
    logic          issue_i;
    logic          issue_use_rd_i;
    logic [AW-1:0] issue_rd_i;
    logic          chk_use_rs1_i;
    logic          chk_use_rs2_i;
    logic [AW-1:0] chk_rs1_i;
    logic [AW-1:0] chk_rs2_i;
    logic          stall_o;

    int tests_run  = 0;
    int tests_fail = 0;

    wb_arbiter #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exu_wb_valid_i(exu_wb_valid_i),
        .exu_wb_rd_i   (exu_wb_rd_i),
        .exu_wb_dat_i  (exu_wb_dat_i),
        .exu_wb_ready_o(exu_wb_ready_o),
        .lsu_wb_valid_i(lsu_wb_valid_i),
        .lsu_wb_rd_i   (lsu_wb_rd_i),
        .lsu_wb_dat_i  (lsu_wb_dat_i),
        .lsu_wb_ready_o(lsu_wb_ready_o),
        .rf_wen_o      (rf_wen_o),
        .rf_rd_o       (rf_rd_o),
        .rf_dat_o      (rf_dat_o),
        .issue_i       (issue_i),
        .issue_use_rd_i(issue_use_rd_i),
        .issue_rd_i    (issue_rd_i),
        .chk_use_rs1_i (chk_use_rs1_i),
        .chk_use_rs2_i (chk_use_rs2_i),
        .chk_rs1_i     (chk_rs1_i),
        .chk_rs2_i     (chk_rs2_i),
        .stall_o       (stall_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle and step 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both writeback requesters.
    task automatic applyStimulus(input logic ev, input logic [AW-1:0] er, input logic [DW-1:0] ed,
                                 input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
        exu_wb_valid_i = ev;
        exu_wb_rd_i    = er;
        exu_wb_dat_i   = ed;
        lsu_wb_valid_i = lv;
        lsu_wb_rd_i    = lr;
        lsu_wb_dat_i   = ld;
    endtask

    // One comparison with an immediate assertion.
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        issue_i        = 1'b0;
        issue_use_rd_i = 1'b0;
        issue_rd_i     = '0;
        chk_use_rs1_i  = 1'b0;
        chk_use_rs2_i  = 1'b0;
        chk_rs1_i      = '0;
        chk_rs2_i      = '0;
        applyStimulus(1'b1, 5'd4, 32'h1, 1'b1, 5'd6, 32'h2);

        // Reset: no readies, no stall, cleared write port.
        tick();
        tick();
        #1;
        checkOutput("rst_exu_ready", {31'd0, exu_wb_ready_o}, 32'd0);
        checkOutput("rst_lsu_ready", {31'd0, lsu_wb_ready_o}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("rst_wen", {31'd0, rf_wen_o}, 32'd0);
        checkOutput("rst_rd", {27'd0, rf_rd_o}, 32'd0);
        checkOutput("rst_dat", rf_dat_o, 32'd0);

        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        rst_n = 1'b1;
        tick();

        // EXU alone: rd=5, dat=0x1234.
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        #1;
        checkOutput("exu_alone_ready", {31'd0, exu_wb_ready_o}, 32'd1);
        checkOutput("exu_alone_lsu_ready", {31'd0, lsu_wb_ready_o}, 32'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("exu_alone_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("exu_alone_rd", {27'd0, rf_rd_o}, 32'd5);
        checkOutput("exu_alone_dat", rf_dat_o, 32'h1234);
        tick();
        checkOutput("idle_wen", {31'd0, rf_wen_o}, 32'd0);

        // LSU alone: rd=9, dat=0x99.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        #1;
        checkOutput("lsu_alone_ready", {31'd0, lsu_wb_ready_o}, 32'd1);
        checkOutput("lsu_alone_exu_ready", {31'd0, exu_wb_ready_o}, 32'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("lsu_alone_rd", {27'd0, rf_rd_o}, 32'd9);
        checkOutput("lsu_alone_dat", rf_dat_o, 32'h99);
        tick();

        // Four conflict cycles: EXU, LSU, EXU, LSU.
        applyStimulus(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hB0);
        #1;
        checkOutput("rr0_exu_ready", {31'd0, exu_wb_ready_o}, 32'd1);
        checkOutput("rr0_lsu_ready", {31'd0, lsu_wb_ready_o}, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB0);
        #1;
        checkOutput("rr1_lsu_ready", {31'd0, lsu_wb_ready_o}, 32'd1);
        checkOutput("rr1_exu_ready", {31'd0, exu_wb_ready_o}, 32'd0);
        checkOutput("rr1_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("rr1_dat", rf_dat_o, 32'hA0);
        tick();
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB1);
        #1;
        checkOutput("rr2_exu_ready", {31'd0, exu_wb_ready_o}, 32'd1);
        checkOutput("rr2_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("rr2_rd", {27'd0, rf_rd_o}, 32'd2);
        checkOutput("rr2_dat", rf_dat_o, 32'hB0);
        tick();
        applyStimulus(1'b1, 5'd1, 32'hA2, 1'b1, 5'd2, 32'hB1);
        #1;
        checkOutput("rr3_lsu_ready", {31'd0, lsu_wb_ready_o}, 32'd1);
        checkOutput("rr3_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("rr3_dat", rf_dat_o, 32'hA1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("rr4_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("rr4_dat", rf_dat_o, 32'hB1);
        tick();
        checkOutput("rr_idle_wen", {31'd0, rf_wen_o}, 32'd0);

        // RAW hazard on rd=7 released by its writeback.
        issue_i        = 1'b1;
        issue_use_rd_i = 1'b1;
        issue_rd_i     = 5'd7;
        #1;
        checkOutput("raw_issue_stall", {31'd0, stall_o}, 32'd0);
        tick();
        issue_i        = 1'b0;
        issue_use_rd_i = 1'b0;
        chk_use_rs1_i  = 1'b1;
        chk_rs1_i      = 5'd7;
        #1;
        checkOutput("raw_stall_a", {31'd0, stall_o}, 32'd1);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
        #1;
        checkOutput("raw_stall_grant", {31'd0, stall_o}, 32'd1);
        checkOutput("raw_grant_ready", {31'd0, exu_wb_ready_o}, 32'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("raw_wb_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("raw_wb_rd", {27'd0, rf_rd_o}, 32'd7);
        checkOutput("raw_stall_wb", {31'd0, stall_o}, 32'd1);
        tick();
        checkOutput("raw_stall_clear", {31'd0, stall_o}, 32'd0);
        chk_use_rs1_i = 1'b0;

        // rd=0 is never busy and never written.
        issue_i        = 1'b1;
        issue_use_rd_i = 1'b1;
        issue_rd_i     = 5'd0;
        tick();
        issue_i        = 1'b0;
        issue_use_rd_i = 1'b0;
        chk_use_rs1_i  = 1'b1;
        chk_rs1_i      = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
        #1;
        checkOutput("r0_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("r0_ready", {31'd0, exu_wb_ready_o}, 32'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        chk_use_rs1_i = 1'b0;
        #1;
        checkOutput("r0_wen", {31'd0, rf_wen_o}, 32'd0);
        tick();

        // Issue of rd=3 in the same cycle rd=3 is written keeps it busy.
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        issue_i        = 1'b1;
        issue_use_rd_i = 1'b1;
        issue_rd_i     = 5'd3;
        #1;
        checkOutput("same_wen", {31'd0, rf_wen_o}, 32'd1);
        checkOutput("same_issue_stall", {31'd0, stall_o}, 32'd0);
        tick();
        issue_i        = 1'b0;
        issue_use_rd_i = 1'b0;
        chk_use_rs2_i  = 1'b1;
        chk_rs2_i      = 5'd3;
        #1;
        checkOutput("same_rs2_stall", {31'd0, stall_o}, 32'd1);

        // Move pointer to LSU with one conflict, then reset over a grant.
        applyStimulus(1'b1, 5'd10, 32'hC0, 1'b1, 5'd11, 32'hD0);
        tick();
        applyStimulus(1'b1, 5'd12, 32'hE0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'd0, exu_wb_ready_o}, 32'd0);
        checkOutput("midrst_stall", {31'd0, stall_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd13, 32'hF0, 1'b1, 5'd14, 32'hF1);
        #1;
        checkOutput("postrst_wen", {31'd0, rf_wen_o}, 32'd0);
        checkOutput("postrst_dat", rf_dat_o, 32'd0);
        checkOutput("postrst_busy_clear", {31'd0, stall_o}, 32'd0);
        checkOutput("postrst_exu_wins", {31'd0, exu_wb_ready_o}, 32'd1);
        checkOutput("postrst_lsu_loses", {31'd0, lsu_wb_ready_o}, 32'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        chk_use_rs2_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
